lcd_reader: RTL and testbench
=============================

Name: lcd_reader

Overview:
- Read-side companion to the HD44780 LCD write controller on the DE2 LCD module.
- Executes HD44780 read cycles (RW=1):
  - status read (RS=0): returns busy flag BF and address counter AC.
  - data read (RS=1): returns the DDRAM/CGRAM byte at AC.
  - busy poll: repeats status reads until BF=0.
- Owns the LCD pins only while rd_active=1. The top-level muxes EN/RS/RW with the writer and tri-states the LCD_DATA pad driver while rd_active=1.

Parameters:
- SETUP_CYC, 3, clocks RS/RW stable before EN rises (tAS ≥ 40 ns at 50 MHz); range 1..255.
- PULSE_CYC, 15, clocks EN held high (≥ 230 ns); data is sampled on the last of these; range 1..255.
- HOLD_CYC, 12, clocks EN low after the pulse, before the next cycle or release (cycle ≥ 500 ns); range 1..255.
- POLL_GAP_CYC, 25, idle clocks between consecutive busy-poll reads; range 1..255.
- TIMEOUT_CYC, 100000, poll timeout in clocks; used only with the macro; must be < 2^20.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_op  in  2  request opcode: 00 status read, 01 data read, 10 busy poll, 11 reserved.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_data  out  8  raw byte captured from the bus.
- resp_busy  out  1  resp_data[7] for status/poll; 0 for data read.
- resp_addr  out  7  resp_data[6:0] for status/poll; 0 for data read.
- resp_err  out  1  set for a reserved opcode.
- resp_timeout  out  1  poll timed out; tied 0 without the macro.
- lcd_data_in  in  8  LCD_DATA pad input.
- LCD_EN  out  1  enable strobe.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  1 = read.
- rd_active  out  1  reader owns the bus.

Behaviour:
- Reset values: all outputs 0 except req_ready=1; state IDLE; all counters 0. rst takes effect on the next clk edge.
- Reset mid-cycle: next edge drives EN=0, rd_active=0, state IDLE. No resp_valid is generated.
- Handshake: a request is accepted when req_valid && req_ready. req_op is latched on that edge and req_ready drops on the next cycle.
- States: IDLE, SETUP, PULSE, HOLD, GAP, RESP.
- Reserved opcode (req_op=11): IDLE→RESP directly, one cycle later. resp_err=1, resp_data=0, LCD pins untouched.
- IDLE→SETUP on accept:
  - rd_active=1, RW=1, RS=(op==01), EN=0.
  - Stay SETUP_CYC cycles.
- SETUP→PULSE:
  - EN=1 for PULSE_CYC cycles.
  - On the last PULSE cycle, lcd_data_in is registered into the capture register.
- PULSE→HOLD:
  - EN=0, RW and RS held, for HOLD_CYC cycles.
- HOLD exit:
  - op 00 or 01 → RESP.
  - op 10 with captured bit7=1 → GAP.
  - op 10 with captured bit7=0 → RESP.
- GAP:
  - rd_active=1, EN=0, RW=1, for POLL_GAP_CYC cycles.
  - Then → SETUP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_* reflect the last capture.
  - rd_active=0, RW=0, RS=0.
  - Next state IDLE.
- resp_* registers hold their values until the next RESP. resp_valid alone marks new data.
- Latency, accept to resp_valid (single read): SETUP_CYC+PULSE_CYC+HOLD_CYC+1 = 31 cycles at defaults.
- Poll with N busy reads before a clear read: (N+1)·30 + N·POLL_GAP_CYC + 1 cycles.
- A req_valid held high during RESP is not accepted until IDLE, because req_ready=0 in RESP.
- Counters: 8-bit down-counters loaded with (PARAM−1), exit when 0. The timeout counter is 20 bits, saturating.

Optional Feature:
- Macro: LCD_READER_BUSY_TIMEOUT_EN.
- Defined:
  - The timeout counter clears on acceptance of op 10 and increments every cycle of the poll.
  - When it reaches TIMEOUT_CYC during GAP, go to RESP with resp_timeout=1 and resp_busy=1.
  - When it reaches TIMEOUT_CYC during SETUP/PULSE/HOLD, the current read completes first; then RESP with resp_timeout=1, unless that read saw BF=0.
- Undefined:
  - Polls run indefinitely until BF=0.
  - resp_timeout is constant 0; no timeout counter is synthesized.

Decomposition:
- Package lcd_pkg:
  - opcode constants OP_STATUS=2'b00, OP_DATA=2'b01, OP_POLL=2'b10, OP_RSVD=2'b11.
  - state encoding.
  - BF_BIT=7, AC_W=7.
- Sub-module lcd_cycle_timer: 8-bit loadable down-counter with load/value/done, instantiated once and reused across SETUP/PULSE/HOLD/GAP.

Test Plan:
- Reset release: after rst, req_ready=1, EN=RW=RS=rd_active=resp_valid=0. Reset asserted during PULSE → EN=0 and state IDLE on the next edge, with no resp_valid.
- Status read: op 00, bus model returns 8'h45 during EN. Check RS=0, RW=1, and EN high exactly 15 cycles after 3 setup cycles. resp_valid at cycle 31 with resp_busy=0, resp_addr=7'h45.
- Data read: op 01, bus returns 8'h41 ('A'). Check RS=1 throughout, resp_data=8'h41, resp_busy=0, resp_addr=0.
- Busy poll: model returns 8'hA0 for 3 reads, then 8'h20. Expect 4 EN pulses, 25-cycle gaps, one resp_valid, resp_busy=0, resp_addr=7'h20.
- Reserved op and back-to-back:
  - op 11 → resp_valid 1 cycle after accept, resp_err=1, EN never pulses.
  - req_valid held high → the second request is accepted only after return to IDLE.
- With LCD_READER_BUSY_TIMEOUT_EN and TIMEOUT_CYC=200, bus stuck at 8'h80 → resp_valid with resp_timeout=1, resp_busy=1, rd_active=0 afterwards.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared opcodes, state encoding and field positions for the HD44780 read-side controller.
package lcd_pkg;

   localparam logic [1:0] OP_STATUS = 2'b00;
   localparam logic [1:0] OP_DATA   = 2'b01;
   localparam logic [1:0] OP_POLL   = 2'b10;
   localparam logic [1:0] OP_RSVD   = 2'b11;

   localparam int unsigned BF_BIT = 7;
   localparam int unsigned AC_W   = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_GAP,
      S_RESP
   } state_t;

endpackage

// File: rtl/lcd_reader_if.sv
// Request/response channel between a client and lcd_reader; master issues reads, slave serves them.
interface lcd_reader_if;
   import lcd_pkg::*;

   logic            req_valid;
   logic [1:0]      req_op;
   logic            req_ready;
   logic            resp_valid;
   logic [7:0]      resp_data;
   logic            resp_busy;
   logic [AC_W-1:0] resp_addr;
   logic            resp_err;
   logic            resp_timeout;

   modport master (
      output req_valid, req_op,
      input  req_ready, resp_valid, resp_data, resp_busy, resp_addr, resp_err, resp_timeout
   );

   modport slave (
      input  req_valid, req_op,
      output req_ready, resp_valid, resp_data, resp_busy, resp_addr, resp_err, resp_timeout
   );

endinterface

// File: rtl/lcd_cycle_timer.sv
// 8-bit loadable down-counter that times every phase of an LCD read cycle; done while value is zero.
module lcd_cycle_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       done
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (value != '0) begin
         value <= value - 8'd1;
      end
   end

   assign done = (value == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read controller: status read, data read and busy poll on the DE2 LCD bus.
// Optional poll timeout enabled by defining LCD_READER_BUSY_TIMEOUT_EN.
module lcd_reader
   import lcd_pkg::*;
#(
`ifdef LCD_READER_BUSY_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYC  = 100000,
`endif
   parameter int unsigned SETUP_CYC    = 3,
   parameter int unsigned PULSE_CYC    = 15,
   parameter int unsigned HOLD_CYC     = 12,
   parameter int unsigned POLL_GAP_CYC = 25
) (
   input  logic       clk,
   input  logic       rst,
   lcd_reader_if.slave bus,
   input  logic [7:0] lcd_data_in,
   output logic       LCD_EN,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       rd_active
);

   localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
   localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
   localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
   localparam logic [7:0] GAP_LD   = 8'(POLL_GAP_CYC - 1);

   state_t          state, state_nxt;
   logic [1:0]      op_q;
   logic [7:0]      cap;
   logic            tmr_load;
   logic [7:0]      tmr_ld_val;
   logic [7:0]      tmr_value_unused;
   logic            tmr_done;
   logic            tmo_hit;
   logic            resp_set;
   logic            resp_err_nxt;
   logic            resp_tmo_nxt;
   logic            accept;

   assign accept = (state == S_IDLE) && bus.req_valid;

   lcd_cycle_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_ld_val),
      .value    (tmr_value_unused),
      .done     (tmr_done)
   );

`ifdef LCD_READER_BUSY_TIMEOUT_EN
   localparam logic [19:0] TMO_LIM = 20'(TIMEOUT_CYC);
   logic [19:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (accept && bus.req_op == OP_POLL) begin
         tmo_cnt <= '0;
      end else if (rd_active && op_q == OP_POLL && tmo_cnt != '1) begin
         tmo_cnt <= tmo_cnt + 20'd1;
      end
   end

   assign tmo_hit = (op_q == OP_POLL) && (tmo_cnt >= TMO_LIM);
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      tmr_load     = 1'b0;
      tmr_ld_val   = '0;
      resp_set     = 1'b0;
      resp_err_nxt = 1'b0;
      resp_tmo_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (bus.req_op == OP_RSVD) begin
                  state_nxt    = S_RESP;
                  resp_set     = 1'b1;
                  resp_err_nxt = 1'b1;
               end else begin
                  state_nxt  = S_SETUP;
                  tmr_load   = 1'b1;
                  tmr_ld_val = SETUP_LD;
               end
            end
         end
         S_SETUP: begin
            if (tmr_done) begin
               state_nxt  = S_PULSE;
               tmr_load   = 1'b1;
               tmr_ld_val = PULSE_LD;
            end
         end
         S_PULSE: begin
            if (tmr_done) begin
               state_nxt  = S_HOLD;
               tmr_load   = 1'b1;
               tmr_ld_val = HOLD_LD;
            end
         end
         S_HOLD: begin
            // A timed-out poll still finishes its read; a clear BF in that read wins over the timeout.
            if (tmr_done) begin
               if (op_q == OP_POLL && cap[BF_BIT]) begin
                  if (tmo_hit) begin
                     state_nxt    = S_RESP;
                     resp_set     = 1'b1;
                     resp_tmo_nxt = 1'b1;
                  end else begin
                     state_nxt  = S_GAP;
                     tmr_load   = 1'b1;
                     tmr_ld_val = GAP_LD;
                  end
               end else begin
                  state_nxt = S_RESP;
                  resp_set  = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (tmo_hit) begin
               state_nxt    = S_RESP;
               resp_set     = 1'b1;
               resp_tmo_nxt = 1'b1;
            end else if (tmr_done) begin
               state_nxt  = S_SETUP;
               tmr_load   = 1'b1;
               tmr_ld_val = SETUP_LD;
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= OP_STATUS;
         cap  <= '0;
      end else begin
         if (accept) begin
            op_q <= bus.req_op;
         end
         if (state == S_PULSE && tmr_done) begin
            cap <= lcd_data_in;
         end
      end
   end

   // Response fields update only when entering RESP and hold until the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.resp_data    <= '0;
         bus.resp_busy    <= 1'b0;
         bus.resp_addr    <= '0;
         bus.resp_err     <= 1'b0;
         bus.resp_timeout <= 1'b0;
      end else if (resp_set) begin
         bus.resp_err     <= resp_err_nxt;
         bus.resp_timeout <= resp_tmo_nxt;
         if (resp_err_nxt) begin
            bus.resp_data <= '0;
            bus.resp_busy <= 1'b0;
            bus.resp_addr <= '0;
         end else if (op_q == OP_DATA) begin
            bus.resp_data <= cap;
            bus.resp_busy <= 1'b0;
            bus.resp_addr <= '0;
         end else begin
            bus.resp_data <= cap;
            bus.resp_busy <= cap[BF_BIT] | resp_tmo_nxt;
            bus.resp_addr <= cap[AC_W-1:0];
         end
      end
   end

   assign bus.req_ready  = (state == S_IDLE);
   assign bus.resp_valid = (state == S_RESP);
   assign rd_active      = (state == S_SETUP) || (state == S_PULSE) ||
                           (state == S_HOLD)  || (state == S_GAP);
   assign LCD_RW         = rd_active;
   assign LCD_EN         = (state == S_PULSE);
   assign LCD_RS         = ((state == S_SETUP) || (state == S_PULSE) || (state == S_HOLD)) &&
                           (op_q == OP_DATA);

endmodule

// File: tb/tb_lcd_reader.sv
// Directed table-driven bench for lcd_reader with an LCD bus model that only drives valid data on the last EN cycle.
module tb_lcd_reader;
   import lcd_pkg::*;

   localparam int unsigned PULSE   = 15;
   localparam int unsigned EN_GAP  = 40;
   localparam int unsigned MAX_CYC = 2000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] lcd_data_in;
   logic       lcd_en, lcd_rs, lcd_rw, rd_active;

   int unsigned checks = 0;
   int unsigned errors = 0;

   lcd_reader_if bus();

   lcd_reader #(
`ifdef LCD_READER_BUSY_TIMEOUT_EN
      .TIMEOUT_CYC  (200),
`endif
      .SETUP_CYC    (3),
      .PULSE_CYC    (15),
      .HOLD_CYC     (12),
      .POLL_GAP_CYC (25)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .lcd_data_in (lcd_data_in),
      .LCD_EN      (lcd_en),
      .LCD_RS      (lcd_rs),
      .LCD_RW      (lcd_rw),
      .rd_active   (rd_active)
   );

   always #10 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      string           name;
      logic [1:0]      op;
      logic [3:0][7:0] script;
      logic [7:0]      data;
      logic            busy;
      logic [6:0]      addr;
      logic            err;
      int unsigned     lat;
      int unsigned     pulses;
   } vec_t;

   vec_t vt[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Script entry k is the byte the LCD returns for the k-th read; entries past 3 repeat entry 3.
   task automatic do_txn(input logic [1:0] op, input logic [3:0][7:0] script,
                         output int unsigned lat, output int unsigned pulses,
                         output int unsigned first_rise, output bit timing_ok,
                         output bit pins_ok, output bit ready_ok, output bit one_shot);
      int unsigned cyc, run, last_fall, idx;
      bit prev_en, done;
      lat = 0; pulses = 0; first_rise = 0; timing_ok = 1'b1; pins_ok = 1'b1;
      run = 0; last_fall = 0; idx = 0; prev_en = 1'b0; done = 1'b0; one_shot = 1'b0;
      @(negedge clk);
      ready_ok = bus.req_ready;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      cyc = 1;
      while (!done) begin
         if (lcd_en) begin
            if (!prev_en) begin
               pulses++;
               if (pulses == 1) first_rise = cyc;
               else if (cyc - last_fall != EN_GAP) timing_ok = 1'b0;
               run = 0;
            end
            run++;
         end else if (prev_en) begin
            if (run != PULSE) timing_ok = 1'b0;
            last_fall = cyc;
            idx++;
         end
         prev_en = lcd_en;
         lcd_data_in = (lcd_en && run == PULSE) ? script[(idx > 3) ? 3 : idx] : 8'h5A;
         if (rd_active) begin
            if (!lcd_rw || (lcd_rs != (op == OP_DATA))) pins_ok = 1'b0;
         end else if (lcd_en || lcd_rw || lcd_rs) begin
            pins_ok = 1'b0;
         end
         if (bus.resp_valid) begin
            lat  = cyc;
            done = 1'b1;
         end else if (cyc >= MAX_CYC) begin
            done = 1'b1;
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      @(posedge clk); #1;
      one_shot = !bus.resp_valid && bus.req_ready && !rd_active;
   endtask

   initial begin
      int unsigned lat, pulses, first_rise, pos1, pos2, nresp;
      bit timing_ok, pins_ok, ready_ok, one_shot, seen;

      vt[0] = '{"status",   OP_STATUS, {8'h00, 8'h00, 8'h00, 8'h45}, 8'h45, 1'b0, 7'h45, 1'b0, 31,  1};
      vt[1] = '{"data",     OP_DATA,   {8'h00, 8'h00, 8'h00, 8'h41}, 8'h41, 1'b0, 7'h00, 1'b0, 31,  1};
      vt[2] = '{"data_b7",  OP_DATA,   {8'h00, 8'h00, 8'h00, 8'hC5}, 8'hC5, 1'b0, 7'h00, 1'b0, 31,  1};
      vt[3] = '{"stat_bsy", OP_STATUS, {8'h00, 8'h00, 8'h00, 8'h9A}, 8'h9A, 1'b1, 7'h1A, 1'b0, 31,  1};
      vt[4] = '{"poll3",    OP_POLL,   {8'h20, 8'hA0, 8'hA0, 8'hA0}, 8'h20, 1'b0, 7'h20, 1'b0, 196, 4};
      vt[5] = '{"poll0",    OP_POLL,   {8'h00, 8'h00, 8'h00, 8'h05}, 8'h05, 1'b0, 7'h05, 1'b0, 31,  1};
      vt[6] = '{"rsvd",     OP_RSVD,   {8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 1'b0, 7'h00, 1'b1, 1,   0};

      bus.req_valid = 1'b0;
      bus.req_op    = OP_STATUS;
      lcd_data_in   = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", bus.req_ready, 1);
      check("rst_pins", {lcd_en, lcd_rw, lcd_rs, rd_active}, 4'b0000);
      check("rst_resp", {bus.resp_valid, bus.resp_data, bus.resp_err, bus.resp_timeout}, '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 7; i++) begin
         do_txn(vt[i].op, vt[i].script, lat, pulses, first_rise, timing_ok, pins_ok, ready_ok, one_shot);
         check({vt[i].name, "_ready"}, ready_ok, 1);
         check({vt[i].name, "_lat"}, lat, vt[i].lat);
         check({vt[i].name, "_pulses"}, pulses, vt[i].pulses);
         if (vt[i].pulses != 0) check({vt[i].name, "_first_en"}, first_rise, 4);
         check({vt[i].name, "_timing"}, timing_ok, 1);
         check({vt[i].name, "_pins"}, pins_ok, 1);
         check({vt[i].name, "_data"}, bus.resp_data, vt[i].data);
         check({vt[i].name, "_busy"}, bus.resp_busy, vt[i].busy);
         check({vt[i].name, "_addr"}, bus.resp_addr, vt[i].addr);
         check({vt[i].name, "_err"}, bus.resp_err, vt[i].err);
         check({vt[i].name, "_tmo"}, bus.resp_timeout, 0);
         check({vt[i].name, "_oneshot"}, one_shot, 1);
      end

      // Reserved op held: second accept only after the IDLE cycle.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_RSVD;
      @(posedge clk); #1;
      check("b2b_c1", {bus.resp_valid, bus.req_ready}, 2'b10);
      @(posedge clk); #1;
      check("b2b_c2", {bus.resp_valid, bus.req_ready}, 2'b01);
      @(posedge clk); #1;
      check("b2b_c3", {bus.resp_valid, bus.req_ready, lcd_en}, 3'b100);
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check("b2b_c4", {bus.resp_valid, bus.req_ready}, 2'b01);

      // Status read held: responses at cycles 31 and 63.
      lcd_data_in = 8'h33;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_STATUS;
      pos1 = 0; pos2 = 0; nresp = 0;
      for (int c = 1; c <= 80; c++) begin
         @(posedge clk); #1;
         if (bus.resp_valid) begin
            nresp++;
            if (nresp == 1) pos1 = c;
            if (nresp == 2) begin
               pos2 = c;
               bus.req_valid = 1'b0;
            end
         end
      end
      bus.req_valid = 1'b0;
      check("hold_count", nresp, 2);
      check("hold_pos1", pos1, 31);
      check("hold_pos2", pos2, 63);
      check("hold_addr", bus.resp_addr, 7'h33);

      // Reset during PULSE.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_STATUS;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("mid_en_before", lcd_en, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_pins", {lcd_en, lcd_rw, rd_active}, 3'b000);
      check("mid_rst_idle", {bus.req_ready, bus.resp_valid}, 2'b10);
      check("mid_rst_data", bus.resp_data, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.resp_valid || lcd_en) seen = 1'b1;
      end
      check("mid_rst_quiet", seen, 0);

`ifdef LCD_READER_BUSY_TIMEOUT_EN
      do_txn(OP_POLL, {8'h80, 8'h80, 8'h80, 8'h80}, lat, pulses, first_rise, timing_ok, pins_ok, ready_ok, one_shot);
      check("tmo_done", lat != 0, 1);
      check("tmo_flag", bus.resp_timeout, 1);
      check("tmo_busy", bus.resp_busy, 1);
      check("tmo_timing", timing_ok, 1);
      check("tmo_release", one_shot, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
